lcd_spi_rx: RTL and testbench

// - Receive side of the 4-wire LCD SPI link (cs/dc/sclk/mosi) driven by lcd_write; behaves as an ST7735 panel front end.
// - Oversamples the link on sys_clk, rebuilds 9-bit {dc,byte} words, and decodes CASET/RASET/RAMWR.
// - Emits RGB565 pixel writes with x/y coordinates. Used as an on-chip loopback checker and a panel model.

---
 rtl/lcd_spi_rx_pkg.sv | 20 ++
 rtl/lcd_spi_rx_shift.sv | 89 ++++++++
 rtl/lcd_spi_rx.sv | 174 +++++++++++++++++
 tb/tb_lcd_spi_rx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_rx_pkg.sv
// rtl/lcd_spi_rx_pkg.sv - ST7735 command codes and decoder state encodings for lcd_spi_rx
package lcd_spi_rx_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    DEC_IDLE  = 2'd0,
    DEC_CASET = 2'd1,
    DEC_RASET = 2'd2,
    DEC_RAMWR = 2'd3
  } dec_state_e;

  // Bit 8 of a rebuilt word is the dc line: 0 marks a command byte.
  function automatic logic is_cmd(input logic [8:0] word);
    return ~word[8];
  endfunction

endpackage

// File: rtl/lcd_spi_rx_shift.sv
// rtl/lcd_spi_rx_shift.sv - pin synchronisers, sclk edge detect and 9-bit {dc,byte} word assembly
module lcd_spi_rx_shift
  import lcd_spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       lcd_cs,
  input  logic       lcd_dc,
  input  logic       lcd_sclk,
  input  logic       lcd_mosi,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] dc_sync_q;
  logic                   cs_prev_q;
  logic                   sclk_prev_q;
  logic [6:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic [8:0]             rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;

  logic cs_s, sclk_s, mosi_s, dc_s;
  logic sclk_rise, cs_rise, shift_en, word_done;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // An edge arriving together with the cs rise still belongs to the frame.
  assign shift_en  = sclk_rise & ~(cs_s & cs_prev_q);
  assign word_done = shift_en & (bit_cnt_q == 3'd7);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], lcd_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], lcd_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], lcd_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], lcd_dc};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (shift_en) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (word_done) begin
          rx_data_q  <= {dc_s, shift_q, mosi_s};
          rx_valid_q <= 1'b1;
        end
      end

      if (cs_s) begin
        bit_cnt_q <= '0;
        if (cs_rise && !word_done && (bit_cnt_q != 3'd0 || shift_en)) begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// rtl/lcd_spi_rx.sv - ST7735-style LCD SPI receiver: CASET/RASET/RAMWR decode to RGB565 pixel writes
// Optional LCD_RX_STATS_EN adds cmd_cnt/pix_cnt statistics ports.
module lcd_spi_rx
  import lcd_spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W     = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               lcd_cs,
  input  logic               lcd_dc,
  input  logic               lcd_sclk,
  input  logic               lcd_mosi,
  output logic [8:0]         rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [15:0]        pixel_rgb,
  output logic               pixel_valid
`ifdef LCD_RX_STATS_EN
  ,
  output logic [15:0]        cmd_cnt,
  output logic [31:0]        pix_cnt
`endif
);

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  dec_state_e         state_q;
  logic [1:0]         idx_q;
  logic [COORD_W-1:0] start_hi_q, start_q, end_hi_q;
  logic [COORD_W-1:0] xs_q, xe_q, ys_q, ye_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] x_d, y_d;
  logic [7:0]         hi_byte_q;
  logic               hi_have_q;
  logic [COORD_W-1:0] pixel_x_q, pixel_y_q;
  logic [15:0]        pixel_rgb_q;
  logic               pixel_valid_q;
  logic [7:0]         rx_byte;

  lcd_spi_rx_shift #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shift (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .lcd_cs   (lcd_cs),
    .lcd_dc   (lcd_dc),
    .lcd_sclk (lcd_sclk),
    .lcd_mosi (lcd_mosi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  assign rx_byte = rx_data[7:0];

  // Coordinates arrive as 16-bit big-endian pairs; keep only the low COORD_W bits.
  function automatic logic [COORD_W-1:0] coord_of(input logic [15:0] v);
    return COORD_W'(v);
  endfunction

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == xe_q || x_q == COORD_MAX) begin
      x_d = xs_q;
      y_d = (y_q == ye_q || y_q == COORD_MAX) ? ys_q : y_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= DEC_IDLE;
      idx_q         <= '0;
      start_hi_q    <= '0;
      start_q       <= '0;
      end_hi_q      <= '0;
      xs_q          <= '0;
      ys_q          <= '0;
      xe_q          <= '1;
      ye_q          <= '1;
      x_q           <= '0;
      y_q           <= '0;
      hi_byte_q     <= '0;
      hi_have_q     <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_rgb_q   <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      if (rx_valid) begin
        if (is_cmd(rx_data)) begin
          // Commands are always decoded from scratch; any half-done sequence is dropped.
          idx_q     <= '0;
          hi_have_q <= 1'b0;
          case (rx_byte)
            CMD_CASET: state_q <= DEC_CASET;
            CMD_RASET: state_q <= DEC_RASET;
            CMD_RAMWR: begin
              state_q <= DEC_RAMWR;
              x_q     <= xs_q;
              y_q     <= ys_q;
            end
            default:   state_q <= DEC_IDLE;
          endcase
        end else begin
          case (state_q)
            DEC_CASET, DEC_RASET: begin
              idx_q <= idx_q + 2'd1;
              case (idx_q)
                2'd0: start_hi_q <= coord_of({rx_byte, 8'h00});
                2'd1: start_q    <= start_hi_q | coord_of({8'h00, rx_byte});
                2'd2: end_hi_q   <= coord_of({rx_byte, 8'h00});
                default: begin
                  state_q <= DEC_IDLE;
                  if (state_q == DEC_CASET) begin
                    xs_q <= start_q;
                    xe_q <= end_hi_q | coord_of({8'h00, rx_byte});
                  end else begin
                    ys_q <= start_q;
                    ye_q <= end_hi_q | coord_of({8'h00, rx_byte});
                  end
                end
              endcase
            end
            DEC_RAMWR: begin
              if (!hi_have_q) begin
                hi_byte_q <= rx_byte;
                hi_have_q <= 1'b1;
              end else begin
                hi_have_q     <= 1'b0;
                pixel_rgb_q   <= {hi_byte_q, rx_byte};
                pixel_x_q     <= x_q;
                pixel_y_q     <= y_q;
                pixel_valid_q <= 1'b1;
                x_q           <= x_d;
                y_q           <= y_d;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign pixel_valid = pixel_valid_q;

`ifdef LCD_RX_STATS_EN
  logic [15:0] cmd_cnt_q;
  logic [31:0] pix_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      if (rx_valid && is_cmd(rx_data)) cmd_cnt_q <= cmd_cnt_q + 16'd1;
      if (pixel_valid_q)               pix_cnt_q <= pix_cnt_q + 32'd1;
    end
  end

  assign cmd_cnt = cmd_cnt_q;
  assign pix_cnt = pix_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb/tb_lcd_spi_rx.sv - directed self-checking bench for lcd_spi_rx driven by an lcd_write-style pin model
module tb_lcd_spi_rx;

  localparam int HALFDIV = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        lcd_cs = 1'b1;
  logic        lcd_dc = 1'b0;
  logic        lcd_sclk = 1'b0;
  logic        lcd_mosi = 1'b0;
  logic [8:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [7:0]  pixel_x;
  logic [7:0]  pixel_y;
  logic [15:0] pixel_rgb;
  logic        pixel_valid;
`ifdef LCD_RX_STATS_EN
  logic [15:0] cmd_cnt;
  logic [31:0] pix_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int lat_last = -1;
  int fe_cnt = 0;
  logic [8:0]  rx_log[$];
  logic [31:0] pix_log[$];

  lcd_spi_rx dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .lcd_cs     (lcd_cs),
    .lcd_dc     (lcd_dc),
    .lcd_sclk   (lcd_sclk),
    .lcd_mosi   (lcd_mosi),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_rgb  (pixel_rgb),
    .pixel_valid(pixel_valid)
`ifdef LCD_RX_STATS_EN
    ,
    .cmd_cnt    (cmd_cnt),
    .pix_cnt    (pix_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      rx_log.push_back(rx_data);
      lat_last = cyc - rise_cyc;
    end
    if (frame_err) fe_cnt++;
    if (pixel_valid) pix_log.push_back({pixel_x, pixel_y, pixel_rgb});
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_logs();
    rx_log.delete();
    pix_log.delete();
    fe_cnt = 0;
  endtask

  task automatic do_reset();
    lcd_cs = 1'b1;
    lcd_sclk = 1'b0;
    lcd_mosi = 1'b0;
    lcd_dc = 1'b0;
    sys_rst_n = 1'b0;
    clk_wait(3);
    sys_rst_n = 1'b1;
    clk_wait(4);
    clear_logs();
  endtask

  task automatic cs_low();
    lcd_cs = 1'b0;
    clk_wait(2);
  endtask

  task automatic cs_high();
    clk_wait(2);
    lcd_cs = 1'b1;
    clk_wait(8);
  endtask

  // Mode-0 bit stream, MSB first; optionally raises cs together with the last edge.
  task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits, input bit cs_with_last);
    for (int i = 7; i > 7 - nbits; i--) begin
      lcd_mosi = b[i];
      lcd_dc = dc;
      clk_wait(HALFDIV);
      lcd_sclk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      if (cs_with_last && i == 8 - nbits) lcd_cs = 1'b1;
      clk_wait(HALFDIV);
      lcd_sclk = 1'b0;
    end
  endtask

  task automatic send_word(input logic dc, input logic [7:0] b);
    send_bits(dc, b, 8, 1'b0);
  endtask

  task automatic send_pixel(input logic [15:0] rgb);
    send_word(1'b1, rgb[15:8]);
    send_word(1'b1, rgb[7:0]);
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    send_word(1'b0, cmd);
    send_word(1'b1, b0);
    send_word(1'b1, b1);
    send_word(1'b1, b2);
    send_word(1'b1, b3);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    clk_wait(3);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, pixel_x, pixel_y, pixel_rgb, pixel_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rx_data=%h pixel=%h/%h/%h valid=%b/%b/%b want all 0",
               rx_data, pixel_x, pixel_y, pixel_rgb, rx_valid, frame_err, pixel_valid);
    end
    do_reset();
  endtask

  task automatic test_word_capture();
    do_reset();
    cs_low();
    send_word(1'b0, 8'h11);
    clk_wait(4);
    n_cmp++;
    if (lat_last !== 3) begin
      n_fail++;
      $display("FAIL rx_latency: got %0d cycles want 3", lat_last);
    end
    send_word(1'b1, 8'hA5);
    cs_high();
    n_cmp++;
    if (rx_log.size() !== 2) begin
      n_fail++;
      $display("FAIL word_count: got %0d want 2", rx_log.size());
    end else begin
      n_cmp++;
      if (rx_log[0] !== 9'h011) begin
        n_fail++;
        $display("FAIL word0: got %h want 011", rx_log[0]);
      end
      n_cmp++;
      if (rx_log[1] !== 9'h1A5) begin
        n_fail++;
        $display("FAIL word1: got %h want 1a5", rx_log[1]);
      end
    end
    n_cmp++;
    if (fe_cnt !== 0) begin
      n_fail++;
      $display("FAIL word_frame_err: got %0d want 0", fe_cnt);
    end
  endtask

  task automatic test_window_fill();
    logic [7:0] ex[5] = '{8'd2, 8'd3, 8'd2, 8'd3, 8'd2};
    logic [7:0] ey[5] = '{8'd5, 8'd5, 8'd6, 8'd6, 8'd5};
    do_reset();
    cs_low();
    send_window(8'h2A, 8'h00, 8'h02, 8'h00, 8'h03);
    send_window(8'h2B, 8'h00, 8'h05, 8'h00, 8'h06);
    send_word(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) send_pixel(16'hF800);
    cs_high();
    n_cmp++;
    if (pix_log.size() !== 5) begin
      n_fail++;
      $display("FAIL fill_count: got %0d want 5", pix_log.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= pix_log.size() || pix_log[i] !== {ex[i], ey[i], 16'hF800}) begin
        n_fail++;
        $display("FAIL fill_pixel%0d: got %h want %h", i,
                 (i < pix_log.size()) ? pix_log[i] : 32'hxxxxxxxx, {ex[i], ey[i], 16'hF800});
      end
    end
`ifdef LCD_RX_STATS_EN
    n_cmp++;
    if (cmd_cnt !== 16'd3 || pix_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL stats: got cmd_cnt=%0d pix_cnt=%0d want 3/5", cmd_cnt, pix_cnt);
    end
`endif
  endtask

  task automatic test_coord_max();
    logic [31:0] exp_pix[3] = '{{8'hFE, 8'h07, 16'h0001}, {8'hFF, 8'h07, 16'h0002}, {8'hFE, 8'h07, 16'h0003}};
    do_reset();
    cs_low();
    send_window(8'h2A, 8'h01, 8'hFE, 8'h01, 8'hFF);
    send_window(8'h2B, 8'h00, 8'h07, 8'h00, 8'h07);
    send_word(1'b0, 8'h2C);
    send_pixel(16'h0001);
    send_pixel(16'h0002);
    send_pixel(16'h0003);
    cs_high();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= pix_log.size() || pix_log[i] !== exp_pix[i]) begin
        n_fail++;
        $display("FAIL max_pixel%0d: got %h want %h", i,
                 (i < pix_log.size()) ? pix_log[i] : 32'hxxxxxxxx, exp_pix[i]);
      end
    end
  endtask

  task automatic test_framing();
    do_reset();
    cs_low();
    send_bits(1'b1, 8'hFF, 5, 1'b0);
    cs_high();
    n_cmp++;
    if (fe_cnt !== 1 || rx_log.size() !== 0) begin
      n_fail++;
      $display("FAIL frame_partial: got frame_err=%0d words=%0d want 1/0", fe_cnt, rx_log.size());
    end
    clear_logs();
    cs_low();
    send_word(1'b0, 8'h2C);
    cs_high();
    n_cmp++;
    if (rx_log.size() !== 1 || rx_log[0] !== 9'h02C || fe_cnt !== 0) begin
      n_fail++;
      $display("FAIL frame_recover: got words=%0d first=%h frame_err=%0d want 1/02c/0",
               rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 9'hxxx, fe_cnt);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cs_low();
    send_bits(1'b0, 8'h3A, 8, 1'b1);
    clk_wait(10);
    n_cmp++;
    if (rx_log.size() !== 1 || rx_log[0] !== 9'h03A || fe_cnt !== 0) begin
      n_fail++;
      $display("FAIL cs_with_8th: got words=%0d first=%h frame_err=%0d want 1/03a/0",
               rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 9'hxxx, fe_cnt);
    end
  endtask

  task automatic test_abort();
    do_reset();
    cs_low();
    send_word(1'b0, 8'h2A);
    send_word(1'b1, 8'h00);
    send_word(1'b1, 8'h09);
    send_word(1'b0, 8'h2C);
    send_pixel(16'h1234);
    send_pixel(16'hABCD);
    cs_high();
    n_cmp++;
    if (pix_log.size() !== 2) begin
      n_fail++;
      $display("FAIL abort_count: got %0d want 2", pix_log.size());
    end else begin
      n_cmp++;
      if (pix_log[0] !== {8'd0, 8'd0, 16'h1234}) begin
        n_fail++;
        $display("FAIL abort_pixel0: got %h want 00001234", pix_log[0]);
      end
      n_cmp++;
      if (pix_log[1] !== {8'd1, 8'd0, 16'hABCD}) begin
        n_fail++;
        $display("FAIL abort_pixel1: got %h want 0100abcd", pix_log[1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cs_low();
    send_word(1'b0, 8'h2C);
    send_word(1'b1, 8'h12);
    send_bits(1'b1, 8'h34, 4, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, pixel_x, pixel_y, pixel_rgb, pixel_valid} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rx_data=%h pixel=%h/%h/%h want all 0",
               rx_data, pixel_x, pixel_y, pixel_rgb);
    end
    lcd_cs = 1'b1;
    clk_wait(3);
    sys_rst_n = 1'b1;
    clk_wait(4);
    clear_logs();
    cs_low();
    send_word(1'b1, 8'h56);
    send_word(1'b1, 8'h78);
    cs_high();
    n_cmp++;
    if (pix_log.size() !== 0 || rx_log.size() !== 2) begin
      n_fail++;
      $display("FAIL post_reset_data: got pixels=%0d words=%0d want 0/2", pix_log.size(), rx_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_word_capture();
    test_window_fill();
    test_coord_max();
    test_framing();
    test_simultaneous();
    test_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
